// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse train generator.
package pulse_pkg;

    // Phases of one output pulse; LOW doubles as the mandatory gap.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Counter preload for a phase of `len` cycles, with 0 meaning 1.
    // The counter runs preload..0, so the phase lasts preload+1 cycles.
    function automatic logic [31:0] len_to_load(input logic [31:0] len);
        if (len == 32'd0) begin
            return 32'd0;
        end
        return len - 32'd1;
    endfunction

endpackage

// File: rtl/pulse_len_counter.sv
// Loadable down-counter that times the HIGH and LOW phases.
// It stops at zero and reports zero combinationally.
module pulse_len_counter #(
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [LEN_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 zero
);

    logic [LEN_WIDTH-1:0] cnt;

    // Count register: a load takes priority over a decrement.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Turns single-cycle requests into pulses of programmable width, each
// followed by a programmable low gap. Requests that arrive while a pulse
// is running are queued in a saturating pending counter.
module pulse_train_gen
    import pulse_pkg::*;
#(
    parameter int LEN_WIDTH  = 8,
    parameter int PEND_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  p_in,
    input  logic [LEN_WIDTH-1:0]  high_len,
    input  logic [LEN_WIDTH-1:0]  low_len,
    input  logic                  clr_ovf,
    output logic                  p_out,
    output logic                  busy,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  overflow
);

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    state_t               state;
    state_t               next_state;

    logic                 cnt_load;
    logic [LEN_WIDTH-1:0] cnt_load_val;
    logic                 cnt_dec;
    logic                 cnt_zero;

    logic [LEN_WIDTH-1:0] high_load;
    logic [LEN_WIDTH-1:0] low_load;

    logic                 start_req;
    logic                 consume;
    logic                 drop;

    // Lengths are only used at phase entry, so a change mid-phase lands
    // on the next phase of that kind.
    assign high_load = LEN_WIDTH'(len_to_load(32'(high_len)));
    assign low_load  = LEN_WIDTH'(len_to_load(32'(low_len)));

    // A new pulse may start if one is queued or one arrives right now.
    assign start_req = (pending != '0) || p_in;

    // A request is lost only when it can neither start nor be queued.
    assign drop = p_in && !consume && (pending == PEND_MAX);

    pulse_len_counter #(
        .LEN_WIDTH(LEN_WIDTH)
    ) u_len_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state logic: sequence HIGH -> LOW and chain straight into the
    // next pulse from the end of LOW when work is waiting.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        next_state   = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        consume      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_req) begin
                    next_state   = HIGH;
                    cnt_load     = 1'b1;
                    cnt_load_val = high_load;
                    consume      = 1'b1;
                end
            end
            HIGH: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    next_state   = LOW;
                    cnt_load     = 1'b1;
                    cnt_load_val = low_load;
                end
            end
            LOW: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (start_req) begin
                    next_state   = HIGH;
                    cnt_load     = 1'b1;
                    cnt_load_val = high_load;
                    consume      = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register with registered, glitch-free pulse and busy outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            p_out <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            p_out <= (next_state == HIGH);
            busy  <= (next_state != IDLE);
        end
    end

    // Pending queue depth and sticky overflow; a request that starts a
    // pulse in the same cycle passes straight through without queueing.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            if (p_in && !consume && !drop) begin
                pending <= pending + 1'b1;
            end else if (!p_in && consume) begin
                pending <= pending - 1'b1;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed and randomized checks of pulse_train_gen against a timestamp
// model: each pulse is described by the edge at which it goes low and the
// edge from which a new pulse may start.
module tb_pulse_train_gen;

    localparam int LEN_WIDTH  = 8;
    localparam int PEND_WIDTH = 4;
    localparam int PMAX       = (1 << PEND_WIDTH) - 1;
    localparam longint NEVER  = 64'h0FFF_FFFF_FFFF_FFFF;

    logic                  clock;
    logic                  reset_n;
    logic                  p_in;
    logic [LEN_WIDTH-1:0]  high_len;
    logic [LEN_WIDTH-1:0]  low_len;
    logic                  clr_ovf;
    logic                  p_out;
    logic                  busy;
    logic [PEND_WIDTH-1:0] pending;
    logic                  overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    longint m_e;         // edges since reset
    longint m_high_end;  // edge at which the current pulse goes low
    longint m_free;      // first edge at which a new pulse may start
    int     m_pend;
    bit     m_ovf;

    pulse_train_gen #(
        .LEN_WIDTH  (LEN_WIDTH),
        .PEND_WIDTH (PEND_WIDTH)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .p_in     (p_in),
        .high_len (high_len),
        .low_len  (low_len),
        .clr_ovf  (clr_ovf),
        .p_out    (p_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_e        = 0;
        m_high_end = 0;
        m_free     = 0;
        m_pend     = 0;
        m_ovf      = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using the inputs
    // sampled at that edge.
    task automatic model_edge(input bit p, input int hl, input int ll, input bit clr);
        bit start;
        bit drop;
        m_e++;
        if (m_e == m_high_end) m_free = m_e + ((ll == 0) ? 1 : ll);
        start = (m_e >= m_free) && ((m_pend > 0) || p);
        if (start) begin
            m_high_end = m_e + ((hl == 0) ? 1 : hl);
            m_free     = NEVER;
        end
        drop = p && !start && (m_pend == PMAX);
        if (drop)          m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        if (p && !start && !drop) m_pend++;
        else if (!p && start)     m_pend--;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".p_out"},    32'(p_out),    32'(m_e < m_high_end));
        check({tag, ".busy"},     32'(busy),     32'(m_e < m_free));
        check({tag, ".pending"},  32'(pending),  32'(m_pend));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    // Drive one cycle of inputs, clock it, advance the model, compare.
    task automatic step(input bit p, input int hl, input int ll, input bit clr, input string tag);
        p_in     = p;
        high_len = LEN_WIDTH'(hl);
        low_len  = LEN_WIDTH'(ll);
        clr_ovf  = clr;
        @(posedge clock);
        model_edge(p, hl, ll, clr);
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [6:0] p_trace;
        logic [6:0] b_trace;
        int         runs[$];
        int         run_len;
        bit         rp;
        bit         rclr;
        int         rhl;
        int         rll;

        // Reset state.
        reset_n  = 1'b0;
        p_in     = 1'b0;
        high_len = '0;
        low_len  = '0;
        clr_ovf  = 1'b0;
        model_reset();
        #12;
        compare_all("reset");
        reset_n = 1'b1;
        #1;

        // 1: single request, high 3 / low 2.
        p_trace = '0;
        b_trace = '0;
        step(1'b1, 3, 2, 1'b0, "t1");
        p_trace = {p_trace[5:0], p_out};
        b_trace = {b_trace[5:0], busy};
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 3, 2, 1'b0, "t1");
            p_trace = {p_trace[5:0], p_out};
            b_trace = {b_trace[5:0], busy};
        end
        check("t1.p_out_trace", 32'(p_trace), 32'(7'b1110000));
        check("t1.busy_trace",  32'(b_trace), 32'(7'b1111100));

        // 2: four back-to-back requests.
        for (int i = 0; i < 4; i++) step(1'b1, 3, 2, 1'b0, "t2");
        check("t2.pending_peak", 32'(pending), 32'd3);
        for (int i = 0; i < 20; i++) step(1'b0, 3, 2, 1'b0, "t2");

        // 3: saturation, overflow clear, and set-over-clear priority.
        for (int i = 0; i < 20; i++) step(1'b1, 10, 2, 1'b0, "t3");
        check("t3.pending_sat", 32'(pending),  32'(PMAX));
        check("t3.ovf_set",     32'(overflow), 32'd1);
        step(1'b0, 10, 2, 1'b1, "t3");
        check("t3.ovf_cleared", 32'(overflow), 32'd0);
        step(1'b1, 10, 2, 1'b1, "t3");
        check("t3.ovf_set_wins", 32'(overflow), 32'd1);

        // 6: asynchronous reset while HIGH with five requests queued.
        for (int i = 0; i < 400; i++) begin
            if (m_pend == 5 && m_e < m_high_end) break;
            step(1'b0, 10, 2, 1'b0, "t6.drain");
        end
        check("t6.pend_before", 32'(pending), 32'd5);
        check("t6.high_before", 32'(p_out),   32'd1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t6.p_out_async",   32'(p_out),    32'd0);
        check("t6.busy_async",    32'(busy),     32'd0);
        check("t6.pending_async", 32'(pending),  32'd0);
        check("t6.ovf_async",     32'(overflow), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 3, 2, 1'b0, "t6.after");
        check("t6.idle_after", 32'(busy), 32'd0);

        // 4: zero lengths with continuous requests -> 1/1 square wave.
        for (int i = 0; i < 12; i++) step(1'b1, 0, 0, 1'b0, "t4");
        check("t4.pending_growth", 32'(pending), 32'd6);
        for (int i = 0; i < 20; i++) step(1'b0, 0, 0, 1'b0, "t4");

        // 5: high_len changes 3 -> 6 while the first pulse is high.
        step(1'b1, 3, 2, 1'b0, "t5");
        runs.push_back(int'(p_out));
        step(1'b0, 3, 2, 1'b0, "t5");
        runs.push_back(int'(p_out));
        step(1'b1, 6, 2, 1'b0, "t5");
        runs.push_back(int'(p_out));
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 6, 2, 1'b0, "t5");
            runs.push_back(int'(p_out));
        end
        begin
            int widths[$];
            run_len = 0;
            foreach (runs[i]) begin
                if (runs[i] != 0) run_len++;
                else if (run_len != 0) begin
                    widths.push_back(run_len);
                    run_len = 0;
                end
            end
            if (run_len != 0) widths.push_back(run_len);
            check("t5.pulse_count", 32'(widths.size()), 32'd2);
            if (widths.size() == 2) begin
                check("t5.first_width",  32'(widths[0]), 32'd3);
                check("t5.second_width", 32'(widths[1]), 32'd6);
            end
        end

        // Randomized traffic with varying lengths and occasional clears.
        for (int i = 0; i < 400; i++) begin
            rp   = ($urandom_range(0, 9) < 4);
            rclr = ($urandom_range(0, 15) == 0);
            rhl  = int'($urandom_range(0, 4));
            rll  = int'($urandom_range(0, 3));
            step(rp, rhl, rll, rclr, "rand");
        end
        for (int i = 0; i < 150; i++) step(1'b0, 1, 1, 1'b1, "rand.drain");
        check("rand.idle_end", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
